// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL lock / reset controller.
//   state_e      : FSM state encoding (3-bit codes visible on STATE)
//   CNT_W        : width of the status counters (RETRY_CNT, LOSS_CNT)
//   timer_width  : timer width sized for the largest cycle parameter
//   sat_inc      : saturating increment for the status counters
package pll_rst_pkg;

    typedef enum logic [2:0] {
        ST_PWRDN     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam int CNT_W = 8;

    // The timer counts 0..N-1 for each cycle parameter, so clog2 of the
    // largest one is enough; never narrower than one bit.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pll_lock_reset_ctrl_sync_2ff.sv
// Generic single-bit two-flop synchronizer, async active-low reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (both flops clear to 0)
//   d     : asynchronous input
//   q     : synchronized output, two clk edges behind d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_reset_ctrl.sv
// PLL lock supervisor and system reset sequencer.
// Powers the PLL up, waits for a synchronized lock that stays high for
// STABLE_CYCLES, then releases SYS_RESET_N. Lock timeouts power-cycle the
// PLL and are counted; lock loss while running is counted and re-qualified.
//
// Ports:
//   CLK, RSTN        : reference clock, async active-low reset
//   PLL_LOCK         : raw PLL lock (asynchronous to CLK)
//   SW_RESTART       : one-cycle request to power-cycle the PLL
//   PLL_POWERDOWN_N  : PLL power control (0 = powered down)
//   SYS_RESET_N      : downstream reset request (1 = released)
//   LOCKED_OK        : high while in RUN
//   STATE            : current state code
//   RETRY_CNT        : consecutive lock timeouts, saturating
//   LOSS_CNT         : lock-loss events since reset, saturating
//   FAULT            : retry limit reached
//
// Optional feature macro: PLL_RETRY_LIMIT_EN. When defined, the timeout
// that brings RETRY_CNT to MAX_RETRIES parks the FSM in FAULT (PLL down)
// until RSTN. When undefined, retries continue forever and FAULT is 0.
module pll_lock_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int PD_CYCLES     = 64,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             PLL_LOCK,
    input  logic             SW_RESTART,
    output logic             PLL_POWERDOWN_N,
    output logic             SYS_RESET_N,
    output logic             LOCKED_OK,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] RETRY_CNT,
    output logic [CNT_W-1:0] LOSS_CNT,
    output logic             FAULT
);

    localparam int TW = timer_width(PD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [TW-1:0] PD_LAST     = TW'(PD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
`ifdef PLL_RETRY_LIMIT_EN
    localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRIES);
`endif

    if (PD_CYCLES < 2 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 1 ||
        MAX_RETRIES < 1 || MAX_RETRIES > 255) begin : g_bad_param
        $error("pll_lock_reset_ctrl: illegal parameter value");
    end

    state_e           state, state_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [CNT_W-1:0] retry, retry_nx;
    logic [CNT_W-1:0] loss, loss_nx;
    logic             lock_s;
    logic             restart;

    sync_2ff u_lock_sync (
        .clk   (CLK),
        .rst_n (RSTN),
        .d     (PLL_LOCK),
        .q     (lock_s)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_PWRDN;
            timer <= '0;
            retry <= '0;
            loss  <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            retry <= retry_nx;
            loss  <= loss_nx;
        end
    end

    always_comb begin
        state_nx = state;
        retry_nx = retry;
        loss_nx  = loss;
        restart  = 1'b0;

        case (state)
            ST_PWRDN: begin
                if (timer == PD_LAST) state_nx = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = ST_STABLE;
                end else if (timer == TIMEOUT_LAST) begin
                    retry_nx = sat_inc(retry);
`ifdef PLL_RETRY_LIMIT_EN
                    state_nx = (retry_nx == RETRY_LIMIT) ? ST_FAULT : ST_PWRDN;
`else
                    state_nx = ST_PWRDN;
`endif
                end
            end
            ST_STABLE: begin
                // Dropout during qualification is a fresh wait, not a loss.
                if (!lock_s) state_nx = ST_WAIT_LOCK;
                else if (timer == STABLE_LAST) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    loss_nx  = sat_inc(loss);
                    state_nx = ST_WAIT_LOCK;
                end
            end
            default: ; // FAULT: held until RSTN
        endcase

        // Software restart overrides every lock/timer event and leaves the
        // counters untouched; FAULT is the only state that ignores it.
        if (SW_RESTART && state != ST_FAULT) begin
            restart  = 1'b1;
            state_nx = ST_PWRDN;
            retry_nx = retry;
            loss_nx  = loss;
        end

        if (state_nx == ST_RUN && state != ST_RUN) retry_nx = '0;

        // Timer free-runs inside a state (wrap in RUN/FAULT is harmless).
        timer_nx = (restart || state_nx != state) ? '0 : timer + TW'(1);
    end

    // Outputs are decoded straight from the state register. SYS_RESET_N only
    // rises on the single-bit 2->3 code change, so its decode cannot glitch.
    assign PLL_POWERDOWN_N = (state == ST_WAIT_LOCK) || (state == ST_STABLE) ||
                             (state == ST_RUN);
    assign SYS_RESET_N     = (state == ST_RUN);
    assign LOCKED_OK       = (state == ST_RUN);
    assign STATE           = state;
    assign RETRY_CNT       = retry;
    assign LOSS_CNT        = loss;
`ifdef PLL_RETRY_LIMIT_EN
    assign FAULT           = (state == ST_FAULT);
`else
    assign FAULT           = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Scoreboard bench for pll_lock_reset_ctrl (PD=4, TIMEOUT=32, STABLE=8,
// MAX_RETRIES=3). Stimulus pushes the expected edge number and output set of
// every state change; a monitor pops one entry per observed STATE change.
module tb_pll_lock_reset_ctrl;

    localparam logic [2:0] S_PWRDN = 3'd0, S_WAIT = 3'd1, S_STABLE = 3'd2,
                           S_RUN = 3'd3, S_FAULT = 3'd4;

    logic       CLK, RSTN, PLL_LOCK, SW_RESTART;
    logic       PLL_POWERDOWN_N, SYS_RESET_N, LOCKED_OK, FAULT;
    logic [2:0] STATE;
    logic [7:0] RETRY_CNT, LOSS_CNT;

    pll_lock_reset_ctrl #(
        .PD_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8), .MAX_RETRIES(3)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .PLL_LOCK(PLL_LOCK), .SW_RESTART(SW_RESTART),
        .PLL_POWERDOWN_N(PLL_POWERDOWN_N), .SYS_RESET_N(SYS_RESET_N),
        .LOCKED_OK(LOCKED_OK), .STATE(STATE), .RETRY_CNT(RETRY_CNT),
        .LOSS_CNT(LOSS_CNT), .FAULT(FAULT)
    );

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       pd, srn, lok, flt;
        logic [7:0] retry, loss;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [2:0] mstate = S_PWRDN;
    int         m_retry = 0;
    int         m_loss = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected Moore outputs for a state, counters from the bench model.
    function automatic void push(input int c, input logic [2:0] st);
        exp_t e;
        e.cyc   = c;
        e.st    = st;
        e.pd    = (st == S_WAIT) || (st == S_STABLE) || (st == S_RUN);
        e.srn   = (st == S_RUN);
        e.lok   = (st == S_RUN);
        e.flt   = (st == S_FAULT);
        e.retry = 8'(m_retry);
        e.loss  = 8'(m_loss);
        q.push_back(e);
        mstate = st;
    endfunction

    // Monitor: every STATE change consumes one scoreboard entry.
    initial begin
        logic [2:0] prev;
        exp_t e;
        prev = S_PWRDN;
        forever begin
            @(negedge CLK);
            if (STATE !== prev) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_transition: state %0d -> %0d at cycle %0d",
                             prev, STATE, cyc);
                end else begin
                    e = q.pop_front();
                    chk("trans_cycle", cyc, e.cyc);
                    chk("trans_state", STATE, e.st);
                    chk("trans_pd_n", PLL_POWERDOWN_N, e.pd);
                    chk("trans_sys_reset_n", SYS_RESET_N, e.srn);
                    chk("trans_locked_ok", LOCKED_OK, e.lok);
                    chk("trans_fault", FAULT, e.flt);
                    chk("trans_retry_cnt", RETRY_CNT, e.retry);
                    chk("trans_loss_cnt", LOSS_CNT, e.loss);
                end
                prev = STATE;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, STATE, S_PWRDN);
        chk({tag, "_pd_n"}, PLL_POWERDOWN_N, 0);
        chk({tag, "_sys_reset_n"}, SYS_RESET_N, 0);
        chk({tag, "_locked_ok"}, LOCKED_OK, 0);
        chk({tag, "_fault"}, FAULT, 0);
        chk({tag, "_retry_cnt"}, RETRY_CNT, 0);
        chk({tag, "_loss_cnt"}, LOSS_CNT, 0);
    endtask

    // Assert RSTN between edges, check outputs before the next edge, then
    // release on a falling edge; t0 is the last edge before release.
    task automatic do_reset(output int t0);
        @(posedge CLK);
        #2;
        m_retry = 0;
        m_loss  = 0;
        if (mstate != S_PWRDN) push(cyc, S_PWRDN);
        RSTN = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        PLL_LOCK   = 1'b0;
        SW_RESTART = 1'b0;
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        t0 = cyc;
        push(t0 + 4, S_WAIT);
    endtask

    initial begin
        int t0, c, s;
        RSTN = 1'b0;
        PLL_LOCK = 1'b0;
        SW_RESTART = 1'b0;
        #3;
        chk_reset_vals("por");
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        t0 = cyc;

        // 1: four cycles of power-down, then lock qualifies in 10 edges.
        push(t0 + 4, S_WAIT);
        wait_to(t0 + 3);
        chk("s1_pd_low_4th_cycle", PLL_POWERDOWN_N, 0);
        wait_to(t0 + 6);
        PLL_LOCK = 1'b1;
        c = cyc;                       // first sampling edge is c+1
        push(c + 3, S_STABLE);
        push(c + 11, S_RUN);
        wait_to(c + 10);
        chk("s1_sys_reset_n_before", SYS_RESET_N, 0);
        wait_to(c + 11);

        // 2: two-cycle dropout during STABLE is not a loss.
        do_reset(t0);
        wait_to(t0 + 4);
        PLL_LOCK = 1'b1;
        s = cyc + 3;
        push(s, S_STABLE);
        wait_to(s + 3);
        PLL_LOCK = 1'b0;
        push(s + 6, S_WAIT);
        wait_to(s + 5);
        PLL_LOCK = 1'b1;
        push(s + 8, S_STABLE);
        push(s + 16, S_RUN);
        wait_to(s + 15);
        chk("s2_sys_reset_n_held", SYS_RESET_N, 0);
        chk("s2_loss_cnt", LOSS_CNT, 0);
        wait_to(s + 16);

        // 3: 300 lock losses in RUN, LOSS_CNT saturates.
        for (int i = 0; i < 300; i++) begin
            c = cyc;
            PLL_LOCK = 1'b0;
            m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            push(c + 3, S_WAIT);
            wait_to(c + 3);
            PLL_LOCK = 1'b1;
            push(c + 6, S_STABLE);
            push(c + 14, S_RUN);
            wait_to(c + 14);
        end
        chk("s3_loss_saturated", LOSS_CNT, 255);

        // 6: async reset in the middle of STABLE.
        c = cyc;
        PLL_LOCK = 1'b0;
        push(c + 3, S_WAIT);
        wait_to(c + 3);
        PLL_LOCK = 1'b1;
        push(c + 6, S_STABLE);
        wait_to(c + 9);
        do_reset(t0);

        // 4: no lock at all -> timeouts every 36 cycles.
`ifdef PLL_RETRY_LIMIT_EN
        for (int k = 1; k <= 3; k++) begin
            m_retry = k;
            push(t0 + 36 * k, (k == 3) ? S_FAULT : S_PWRDN);
            if (k < 3) push(t0 + 36 * k + 4, S_WAIT);
            wait_to(t0 + 36 * k + 2);
        end
        SW_RESTART = 1'b1;
        PLL_LOCK = 1'b1;
        wait_to(cyc + 1);
        SW_RESTART = 1'b0;
        wait_to(cyc + 20);
        chk("s4_fault_state", STATE, S_FAULT);
        chk("s4_fault_flag", FAULT, 1);
        chk("s4_fault_pd_n", PLL_POWERDOWN_N, 0);
`else
        for (int k = 1; k <= 257; k++) begin
            m_retry = (k < 255) ? k : 255;
            push(t0 + 36 * k, S_PWRDN);
            push(t0 + 36 * k + 4, S_WAIT);
            wait_to(t0 + 36 * k + 4);
        end
        chk("s4_retry_saturated", RETRY_CNT, 255);
        chk("s4_fault_tied_low", FAULT, 0);
`endif

        // 5: one timeout, relock (RETRY_CNT clears in RUN), then SW_RESTART
        // coincident with lock_s falling wins over the loss.
        do_reset(t0);
        m_retry = 1;
        push(t0 + 36, S_PWRDN);
        push(t0 + 40, S_WAIT);
        wait_to(t0 + 40);
        PLL_LOCK = 1'b1;
        s = cyc + 3;
        push(s, S_STABLE);
        m_retry = 0;
        push(s + 8, S_RUN);
        wait_to(s + 8);
        c = cyc;
        PLL_LOCK = 1'b0;               // lock_s seen low by the FSM at c+3
        wait_to(c + 2);
        SW_RESTART = 1'b1;
        push(c + 3, S_PWRDN);
        wait_to(c + 3);
        SW_RESTART = 1'b0;
        push(c + 7, S_WAIT);
        wait_to(c + 7);
        PLL_LOCK = 1'b1;
        push(c + 10, S_STABLE);
        push(c + 18, S_RUN);
        wait_to(c + 18);
        chk("s5_loss_unchanged", LOSS_CNT, 0);
        chk("s5_retry_cleared", RETRY_CNT, 0);

        wait_to(cyc + 5);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
